// File: rtl/ifid_elastic_reg.sv
// IF/ID pipeline register with a valid/ready handshake and a 2-entry skid buffer.
// in_ready comes only from registered state, flush and reset, never from out_ready.
module ifid_elastic_reg #(
  parameter int               WIDTH = 32,
  parameter int               LANES = 1,
  parameter logic [WIDTH-1:0] NOP   = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_pcplus4,
  input  logic [LANES*WIDTH-1:0] in_instr,
  input  logic [LANES-1:0]       in_lane_mask,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_pcplus4,
  output logic [LANES*WIDTH-1:0] out_instr,
  output logic [LANES-1:0]       out_lane_mask,
  output logic [1:0]             occupancy
);

  localparam logic [LANES*WIDTH-1:0] NOP_VEC = {LANES{NOP}};

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [WIDTH-1:0]         main_pc_q, main_pc_d;
  logic [LANES*WIDTH-1:0]   main_instr_q, main_instr_d;
  logic [LANES-1:0]         main_mask_q, main_mask_d;
  logic [WIDTH-1:0]         skid_pc_q, skid_pc_d;
  logic [LANES*WIDTH-1:0]   skid_instr_q, skid_instr_d;
  logic [LANES-1:0]         skid_mask_q, skid_mask_d;

  logic accept;
  logic deliver;

  assign in_ready      = (state_q != FULL) & ~flush & rst_n;
  assign out_valid     = (state_q != EMPTY);
  assign out_pcplus4   = main_pc_q;
  assign out_instr     = main_instr_q;
  assign out_lane_mask = main_mask_q;
  assign occupancy     = state_q;

  assign accept  = in_valid & in_ready;
  assign deliver = out_valid & out_ready;

  always_comb begin
    state_d      = state_q;
    main_pc_d    = main_pc_q;
    main_instr_d = main_instr_q;
    main_mask_d  = main_mask_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    skid_mask_d  = skid_mask_q;

    if (flush) begin
      state_d      = EMPTY;
      main_pc_d    = '0;
      main_instr_d = NOP_VEC;
      main_mask_d  = '0;
      skid_pc_d    = '0;
      skid_instr_d = NOP_VEC;
      skid_mask_d  = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d      = BUSY;
            main_pc_d    = in_pcplus4;
            main_instr_d = in_instr;
            main_mask_d  = in_lane_mask;
          end
        end
        BUSY: begin
          if (accept && deliver) begin
            main_pc_d    = in_pcplus4;
            main_instr_d = in_instr;
            main_mask_d  = in_lane_mask;
          end else if (accept) begin
            // Decode is stalled: park the new packet behind the main one.
            state_d      = FULL;
            skid_pc_d    = in_pcplus4;
            skid_instr_d = in_instr;
            skid_mask_d  = in_lane_mask;
          end else if (deliver) begin
            state_d      = EMPTY;
            main_pc_d    = '0;
            main_instr_d = NOP_VEC;
            main_mask_d  = '0;
          end
        end
        FULL: begin
          if (deliver) begin
            state_d      = BUSY;
            main_pc_d    = skid_pc_q;
            main_instr_d = skid_instr_q;
            main_mask_d  = skid_mask_q;
            skid_pc_d    = '0;
            skid_instr_d = NOP_VEC;
            skid_mask_d  = '0;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      main_pc_q    <= '0;
      main_instr_q <= NOP_VEC;
      main_mask_q  <= '0;
      skid_pc_q    <= '0;
      skid_instr_q <= NOP_VEC;
      skid_mask_q  <= '0;
    end else begin
      state_q      <= state_d;
      main_pc_q    <= main_pc_d;
      main_instr_q <= main_instr_d;
      main_mask_q  <= main_mask_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_mask_q  <= skid_mask_d;
    end
  end

endmodule

// File: tb/tb_ifid_elastic_reg.sv
// Directed and randomised checks of ifid_elastic_reg with two lanes and a non-zero NOP.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_ifid_elastic_reg;

  localparam int          WIDTH = 32;
  localparam int          LANES = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   flush = 1'b0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_pcplus4 = '0;
  logic [LANES*WIDTH-1:0] in_instr = '0;
  logic [LANES-1:0]       in_lane_mask = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [WIDTH-1:0]       out_pcplus4;
  logic [LANES*WIDTH-1:0] out_instr;
  logic [LANES-1:0]       out_lane_mask;
  logic [1:0]             occupancy;

  int assertions = 0;
  int failures   = 0;

  logic [127:0] model_q[$];

  ifid_elastic_reg #(.WIDTH(WIDTH), .LANES(LANES), .NOP(NOP)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_pcplus4    (in_pcplus4),
    .in_instr      (in_instr),
    .in_lane_mask  (in_lane_mask),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pcplus4   (out_pcplus4),
    .out_instr     (out_instr),
    .out_lane_mask (out_lane_mask),
    .occupancy     (occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mk_instr(input logic [31:0] pc);
    return {pc ^ 32'h5A5A_0000, pc ^ 32'hA5A5_0000};
  endfunction

  function automatic logic [127:0] pkt(input logic [31:0] pc, input logic [1:0] mask);
    return {30'b0, pc, mk_instr(pc), mask};
  endfunction

  function automatic logic [127:0] idle_pkt();
    return {30'b0, 32'h0, NOP, NOP, 2'b00};
  endfunction

  function automatic logic [127:0] out_pkt();
    return {30'b0, out_pcplus4, out_instr, out_lane_mask};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    assertions++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [1:0] mask,
                               input logic ordy, input logic fl, input logic rn);
    @(negedge clk);
    in_valid     = v;
    in_pcplus4   = pc;
    in_instr     = mk_instr(pc);
    in_lane_mask = mask;
    out_ready    = ordy;
    flush        = fl;
    rst_n        = rn;
    #1;
  endtask

  initial begin
    // Reset held for two edges
    applyStimulus(1'b1, 32'h4, 2'b11, 1'b1, 1'b0, 1'b0);
    checkOutput("rst_in_ready_low", 128'(in_ready), 128'(1'b0));
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b1);
    checkOutput("rst_out_valid", 128'(out_valid), 128'(1'b0));
    checkOutput("rst_out_pkt", out_pkt(), idle_pkt());
    checkOutput("rst_occupancy", 128'(occupancy), 128'(2'd0));
    checkOutput("rst_in_ready", 128'(in_ready), 128'(1'b1));

    // Back-to-back stream, one cycle latency
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'(4 * (i + 1)), 2'b11, 1'b1, 1'b0, 1'b1);
      if (i > 0) begin
        checkOutput("stream_pkt", out_pkt(), pkt(32'(4 * i), 2'b11));
        checkOutput("stream_valid", 128'(out_valid), 128'(1'b1));
      end
    end
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 1'b1);
    checkOutput("stream_last", out_pkt(), pkt(32'h10, 2'b11));
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 1'b1);
    checkOutput("stream_drained", 128'(out_valid), 128'(1'b0));
    checkOutput("stream_occ0", 128'(occupancy), 128'(2'd0));

    // Backpressure fills the skid register
    applyStimulus(1'b1, 32'h4, 2'b11, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h8, 2'b11, 1'b0, 1'b0, 1'b1);
    checkOutput("bp_first_A", out_pkt(), pkt(32'h4, 2'b11));
    checkOutput("bp_occ1", 128'(occupancy), 128'(2'd1));
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b1);
    checkOutput("bp_occ2", 128'(occupancy), 128'(2'd2));
    checkOutput("bp_in_ready0", 128'(in_ready), 128'(1'b0));
    checkOutput("bp_hold_A", out_pkt(), pkt(32'h4, 2'b11));
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 1'b1);
    checkOutput("bp_still_A", out_pkt(), pkt(32'h4, 2'b11));
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 1'b1);
    checkOutput("bp_then_B", out_pkt(), pkt(32'h8, 2'b11));
    checkOutput("bp_occ_back1", 128'(occupancy), 128'(2'd1));
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 1'b1);
    checkOutput("bp_empty", 128'(out_valid), 128'(1'b0));

    // Flush while FULL with a packet offered
    applyStimulus(1'b1, 32'h4, 2'b11, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h8, 2'b11, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h20, 2'b11, 1'b0, 1'b1, 1'b1);
    checkOutput("fl_occ2", 128'(occupancy), 128'(2'd2));
    checkOutput("fl_in_ready0", 128'(in_ready), 128'(1'b0));
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b1);
    checkOutput("fl_valid0", 128'(out_valid), 128'(1'b0));
    checkOutput("fl_occ0", 128'(occupancy), 128'(2'd0));
    checkOutput("fl_idle_pkt", out_pkt(), idle_pkt());
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 1'b1);
    checkOutput("fl_never_0x20", 128'(out_valid), 128'(1'b0));

    // Reset together with flush while BUSY
    applyStimulus(1'b1, 32'h4, 2'b11, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h30, 2'b11, 1'b0, 1'b1, 1'b0);
    checkOutput("rf_busy_before", 128'(occupancy), 128'(2'd1));
    checkOutput("rf_in_ready0", 128'(in_ready), 128'(1'b0));
    applyStimulus(1'b1, 32'h40, 2'b01, 1'b1, 1'b0, 1'b1);
    checkOutput("rf_occ0", 128'(occupancy), 128'(2'd0));
    checkOutput("rf_valid0", 128'(out_valid), 128'(1'b0));
    checkOutput("rf_in_ready1", 128'(in_ready), 128'(1'b1));
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 1'b1);
    checkOutput("rf_mask01", 128'(out_lane_mask), 128'(2'b01));
    checkOutput("rf_pkt", out_pkt(), pkt(32'h40, 2'b01));

    // Random traffic against a queue model; the last cycle drained the register
    model_q.delete();
    for (int c = 0; c < 3000; c++) begin
      logic        v, ordy, fl, exp_ready;
      logic [31:0] pc;
      logic [1:0]  mask;
      v    = 1'($urandom_range(0, 1));
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 49) == 0);
      pc   = $urandom;
      mask = 2'($urandom_range(0, 3));
      applyStimulus(v, pc, mask, ordy, fl, 1'b1);
      exp_ready = (model_q.size() < 2) && !fl;
      checkOutput("rnd_in_ready", 128'(in_ready), 128'(exp_ready));
      checkOutput("rnd_occupancy", 128'(occupancy), 128'(model_q.size()));
      checkOutput("rnd_out_valid", 128'(out_valid), 128'(model_q.size() > 0));
      if (model_q.size() > 0) checkOutput("rnd_head_pkt", out_pkt(), model_q[0]);
      else                    checkOutput("rnd_idle_pkt", out_pkt(), idle_pkt());
      if (fl) model_q.delete();
      else begin
        if (model_q.size() > 0 && ordy) void'(model_q.pop_front());
        if (v && exp_ready) model_q.push_back(pkt(pc, mask));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
